// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 master: turns a valid/ready command stream into
// APB transfers and returns one registered response beat per command.
module apb_cmd_master #(
    parameter int          G_ADDR_WIDTH = 13,
    parameter int          G_TIMEOUT    = 256,
    parameter logic [2:0]  G_PPROT      = 3'b000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]             cmd_wdata,
    input  logic [3:0]              cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    rsp_parity_err,
    input  logic                    parity_error,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [31:0]             m_apb_pwdata,
    output logic [3:0]              m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic [31:0]             m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    localparam int CW = (G_TIMEOUT > 0) ? $clog2(G_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(G_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          par;
    logic          par_now;
    logic          expire;

    assign m_apb_pprot = G_PPROT;

    // Saturating count of ACCESS cycles spent without pready
    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
        expire  = (G_TIMEOUT != 0) && (cnt_inc == TMO);
        par_now = par | parity_error;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_slverr     <= 1'b0;
            rsp_timeout    <= 1'b0;
            rsp_parity_err <= 1'b0;
            m_apb_psel     <= 1'b0;
            m_apb_penable  <= 1'b0;
            m_apb_pwrite   <= 1'b0;
            m_apb_paddr    <= '0;
            m_apb_pwdata   <= '0;
            m_apb_pstrb    <= '0;
            cnt            <= '0;
            par            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        m_apb_psel   <= 1'b1;
                        m_apb_pwrite <= cmd_write;
                        m_apb_paddr  <= cmd_addr;
                        m_apb_pwdata <= cmd_wdata;
                        m_apb_pstrb  <= cmd_write ? cmd_strb : 4'h0;
                        cnt          <= '0;
                        par          <= 1'b0;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    m_apb_penable <= 1'b1;
                    par           <= par_now;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    par <= par_now;
                    cnt <= cnt_inc;
                    // pready takes priority over a coincident timeout
                    if (m_apb_pready) begin
                        rsp_rdata      <= m_apb_pwrite ? 32'h0 : m_apb_prdata;
                        rsp_slverr     <= m_apb_pslverr;
                        rsp_timeout    <= 1'b0;
                        rsp_parity_err <= par_now;
                        rsp_valid      <= 1'b1;
                        m_apb_psel     <= 1'b0;
                        m_apb_penable  <= 1'b0;
                        cnt            <= cnt;
                        state          <= RESP;
                    end else if (expire) begin
                        rsp_rdata      <= 32'h0;
                        rsp_slverr     <= 1'b1;
                        rsp_timeout    <= 1'b1;
                        rsp_parity_err <= par_now;
                        rsp_valid      <= 1'b1;
                        m_apb_psel     <= 1'b0;
                        m_apb_penable  <= 1'b0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: vector table of single transfers
// plus hand-written throughput and mid-transfer reset sequences.
module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [12:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        rsp_parity_err;
    logic        parity_error;
    logic        m_apb_psel;
    logic        m_apb_penable;
    logic        m_apb_pwrite;
    logic [2:0]  m_apb_pprot;
    logic [12:0] m_apb_paddr;
    logic [31:0] m_apb_pwdata;
    logic [3:0]  m_apb_pstrb;
    logic        m_apb_pready;
    logic [31:0] m_apb_prdata;
    logic        m_apb_pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .G_ADDR_WIDTH(13),
        .G_TIMEOUT   (4),
        .G_PPROT     (3'b000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_strb      (cmd_strb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_slverr    (rsp_slverr),
        .rsp_timeout   (rsp_timeout),
        .rsp_parity_err(rsp_parity_err),
        .parity_error  (parity_error),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_pprot   (m_apb_pprot),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_pstrb   (m_apb_pstrb),
        .m_apb_pready  (m_apb_pready),
        .m_apb_prdata  (m_apb_prdata),
        .m_apb_pslverr (m_apb_pslverr)
    );

    // waits: ACCESS cycles before pready (255 = never)
    // par_cyc: 1 = SETUP, 2.. = ACCESS cycle index + 1, 0 = none
    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr_in;
        int          par_cyc;
        int          hold;
        logic [31:0] e_rdata;
        logic        e_slverr;
        logic        e_to;
        logic        e_par;
        int          e_nacc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   nacc;
        int   t;
        logic addr_bad;
        logic [31:0] r_rdata;
        nacc     = 0;
        t        = 0;
        addr_bad = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("setup_psel", {m_apb_psel, m_apb_penable}, 2'b10);
        check("setup_paddr", m_apb_paddr, v.addr);
        check("setup_pwrite", m_apb_pwrite, v.wr);
        check("setup_pstrb", m_apb_pstrb, v.wr ? v.strb : 4'h0);
        if (v.wr) check("setup_pwdata", m_apb_pwdata, v.wdata);
        parity_error = (v.par_cyc == 1);
        @(negedge clk);
        while (!rsp_valid && t < 20) begin
            if (m_apb_psel && m_apb_penable) nacc++;
            if (m_apb_paddr !== v.addr) addr_bad = 1'b1;
            m_apb_pready  = (nacc > v.waits);
            m_apb_prdata  = v.prdata;
            m_apb_pslverr = v.slverr_in;
            parity_error  = (v.par_cyc == nacc + 1);
            @(negedge clk);
            t++;
        end
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
        parity_error  = 1'b0;
        check("rsp_valid_seen", rsp_valid, 1);
        check("access_cycles", nacc, v.e_nacc);
        check("paddr_stable", addr_bad, 0);
        check("rsp_rdata", rsp_rdata, v.e_rdata);
        check("rsp_flags", {rsp_slverr, rsp_timeout, rsp_parity_err},
              {v.e_slverr, v.e_to, v.e_par});
        check("resp_bus_idle", {m_apb_psel, m_apb_penable, cmd_ready}, 0);
        r_rdata = rsp_rdata;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("hold_valid", {rsp_valid, m_apb_psel, cmd_ready}, 3'b100);
            check("hold_data", rsp_rdata, r_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        int setups[$];
        logic stale;
        #200000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int   setups[$];
        logic stale;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_addr      = '0;
        cmd_wdata     = '0;
        cmd_strb      = '0;
        rsp_ready     = 1'b0;
        parity_error  = 1'b0;
        m_apb_pready  = 1'b0;
        m_apb_prdata  = '0;
        m_apb_pslverr = 1'b0;

        vecs[0]  = '{1'b1, 13'h010, 32'hA5A5_1234, 4'hF, 0, 32'hDEAD_BEEF,
                     1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 13'h010, 32'h0, 4'h0, 3, 32'hA5A5_1234,
                     1'b0, 0, 0, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0, 4};
        vecs[2]  = '{1'b0, 13'h020, 32'h0, 4'h0, 255, 32'h1234_5678,
                     1'b0, 0, 0, 32'h0, 1'b1, 1'b1, 1'b0, 4};
        vecs[3]  = '{1'b1, 13'h004, 32'h0BAD_F00D, 4'h5, 0, 32'h0,
                     1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{1'b0, 13'h008, 32'h0, 4'h0, 1, 32'h1122_3344,
                     1'b0, 3, 0, 32'h1122_3344, 1'b0, 1'b0, 1'b1, 2};
        vecs[5]  = '{1'b0, 13'h008, 32'h0, 4'h0, 0, 32'h1122_3344,
                     1'b0, 0, 0, 32'h1122_3344, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{1'b0, 13'h00C, 32'h0, 4'h0, 0, 32'h0000_0055,
                     1'b1, 0, 0, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b1, 13'h1FFC, 32'hCAFE_0001, 4'h3, 0, 32'h0,
                     1'b0, 0, 5, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 13'h014, 32'h0, 4'h0, 2, 32'h8765_4321,
                     1'b0, 1, 0, 32'h8765_4321, 1'b0, 1'b0, 1'b1, 3};
        vecs[9]  = '{1'b0, 13'h000, 32'hFFFF_FFFF, 4'hF, 0, 32'hFFFF_0000,
                     1'b0, 0, 0, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 13'h018, 32'h0, 4'h0, 255, 32'h0,
                     1'b1, 4, 0, 32'h0, 1'b1, 1'b1, 1'b1, 4};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cmd_ready, rsp_valid, m_apb_psel, m_apb_penable}, 0);
        check("reset_pprot", m_apb_pprot, 3'b000);
        check("reset_rsp", {rsp_rdata, rsp_slverr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // back-to-back: one SETUP every 4 cycles
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_write    = 1'b0;
        cmd_addr     = 13'h040;
        rsp_ready    = 1'b1;
        m_apb_pready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (m_apb_psel && !m_apb_penable) setups.push_back(c);
            if (c == 15) cmd_valid = 1'b0;
        end
        check("b2b_count", setups.size(), 4);
        foreach (setups[i]) check("b2b_spacing", setups[i], 4 * i);
        rsp_ready    = 1'b0;
        m_apb_pready = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_drained", {cmd_ready, rsp_valid, m_apb_psel}, 3'b100);

        // reset during ACCESS drops the bus asynchronously
        cmd_valid = 1'b1;
        cmd_addr  = 13'h044;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_access", {m_apb_psel, m_apb_penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_bus",
              {m_apb_psel, m_apb_penable, rsp_valid, cmd_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", cmd_ready, 1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || m_apb_psel) stale = 1'b1;
        end
        check("no_stale_rsp", stale, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
